// File: rtl/barrel_rotator_left_arbiter_if.sv
// Request/response bundle for the shared left rotator: per-client {data, rotation}
// on valid/ready, and one rotated result with the index of the client that produced it.
interface barrel_rotator_left_arbiter_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int REQUESTERS     = 4,
    parameter int ROTATION_WIDTH = $clog2(DATA_WIDTH),
    parameter int INDEX_WIDTH    = $clog2(REQUESTERS)
);
    logic [REQUESTERS-1:0]                request_valid;
    logic [REQUESTERS*DATA_WIDTH-1:0]     request_data;
    logic [REQUESTERS*ROTATION_WIDTH-1:0] request_rotation;
    logic [REQUESTERS-1:0]                request_ready;
    logic                                 response_valid;
    logic [DATA_WIDTH-1:0]                response_data;
    logic [INDEX_WIDTH-1:0]               response_index;
    logic                                 response_ready;

    modport master (
        output request_valid, request_data, request_rotation, response_ready,
        input  request_ready, response_valid, response_data, response_index
    );

    modport slave (
        input  request_valid, request_data, request_rotation, response_ready,
        output request_ready, response_valid, response_data, response_index
    );
endinterface

// File: rtl/barrel_rotator_left_arbiter.sv
// Arbitrates REQUESTERS clients onto one barrel left rotator with a one-entry output register.
// Define BARREL_ROTATOR_LEFT_ARBITER_FIXED_PRIORITY_EN for lowest-index-wins instead of round-robin.
module barrel_rotator_left_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int REQUESTERS     = 4,
    parameter int ROTATION_WIDTH = $clog2(DATA_WIDTH),
    parameter int INDEX_WIDTH    = $clog2(REQUESTERS)
) (
    input logic                          clock,
    input logic                          resetn,
    barrel_rotator_left_arbiter_if.slave bus
);
    localparam logic [0:0] STATE_EMPTY = 1'b0;
    localparam logic [0:0] STATE_FULL  = 1'b1;

    logic [0:0]              state;
    logic [DATA_WIDTH-1:0]   out_data;
    logic [INDEX_WIDTH-1:0]  out_index;
    logic [INDEX_WIDTH-1:0]  ptr;
    logic                    can_load;

    logic [REQUESTERS-1:0]   grant;
    logic [INDEX_WIDTH-1:0]  grant_index;
    logic                    grant_any;
    logic [INDEX_WIDTH:0]    scan_sum;
    logic [INDEX_WIDTH-1:0]  scan_idx;

    logic [DATA_WIDTH-1:0]     sel_data;
    logic [ROTATION_WIDTH-1:0] sel_rot;
    logic [ROTATION_WIDTH-1:0] rot_amt;
    logic [2*DATA_WIDTH-1:0]   rot_dbl;

    // Pass-through load: a full register that is draining this cycle can refill.
    assign can_load = (state == STATE_EMPTY) || bus.response_ready;

    // Scan from the pointer upward with wrap; first valid client wins.
    always_comb begin
        grant       = '0;
        grant_index = '0;
        grant_any   = 1'b0;
        scan_sum    = '0;
        scan_idx    = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            scan_sum = {1'b0, ptr} + (INDEX_WIDTH+1)'(k);
            if (scan_sum >= (INDEX_WIDTH+1)'(REQUESTERS))
                scan_sum = scan_sum - (INDEX_WIDTH+1)'(REQUESTERS);
            scan_idx = scan_sum[INDEX_WIDTH-1:0];
            if (!grant_any && bus.request_valid[scan_idx]) begin
                grant_any   = 1'b1;
                grant_index = scan_idx;
            end
        end
        if (!(can_load && resetn))
            grant_any = 1'b0;
        if (grant_any)
            grant[grant_index] = 1'b1;
    end

    always_comb begin
        sel_data = '0;
        sel_rot  = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (grant[i]) begin
                sel_data = bus.request_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_rot  = bus.request_rotation[i*ROTATION_WIDTH +: ROTATION_WIDTH];
            end
        end
    end

    // Doubling the word turns the rotate into a plain shift; the upper half is the result.
    assign rot_amt = ROTATION_WIDTH'(32'(sel_rot) % DATA_WIDTH);
    assign rot_dbl = {sel_data, sel_data} << rot_amt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= STATE_EMPTY;
            out_data  <= '0;
            out_index <= '0;
        end else if (grant_any) begin
            state     <= STATE_FULL;
            out_data  <= rot_dbl[2*DATA_WIDTH-1:DATA_WIDTH];
            out_index <= grant_index;
        end else if (bus.response_ready) begin
            state     <= STATE_EMPTY;
        end
    end

`ifdef BARREL_ROTATOR_LEFT_ARBITER_FIXED_PRIORITY_EN
    assign ptr = '0;
`else
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            ptr <= '0;
        else if (grant_any)
            ptr <= (grant_index == INDEX_WIDTH'(REQUESTERS-1)) ? '0 : grant_index + 1'b1;
    end
`endif

    assign bus.request_ready  = grant;
    assign bus.response_valid = (state == STATE_FULL);
    assign bus.response_data  = out_data;
    assign bus.response_index = out_index;
endmodule

// File: tb/tb_barrel_rotator_left_arbiter.sv
// Directed and random checks of the shared rotator arbiter against a queue-based reference model.
module tb_barrel_rotator_left_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int RW = 3;
  localparam int IW = 2;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  barrel_rotator_left_arbiter_if #(.DATA_WIDTH(DW), .REQUESTERS(NR)) bus ();
  barrel_rotator_left_arbiter #(.DATA_WIDTH(DW), .REQUESTERS(NR)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  typedef struct { int idx; logic [DW-1:0] data; } resp_t;
  resp_t sb[$];
  int ptr_m = 0;
  int last_grant = -1;
  int vectors = 0;
  int miscompares = 0;

`ifdef BARREL_ROTATOR_LEFT_ARBITER_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  function automatic logic [DW-1:0] rotl(logic [DW-1:0] d, int r);
    int s;
    s = r % DW;
    if (s == 0) return d;
    return (d << s) | (d >> (DW - s));
  endfunction

  function automatic int pick(logic [NR-1:0] v, int p);
    for (int k = 0; k < NR; k++)
      if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(int i, logic [DW-1:0] d, logic [RW-1:0] r);
    bus.request_data[i*DW +: DW]     = d;
    bus.request_rotation[i*RW +: RW] = r;
  endtask

  // One clock: compare DUT against the model at the falling edge, then advance the model.
  task automatic cycle();
    int g;
    bit can_load, fire;
    logic [NR-1:0] exp_ready;
    resp_t nr;
    @(negedge clock);
    can_load  = (sb.size() == 0) || bus.response_ready;
    g         = can_load ? pick(bus.request_valid, ptr_m) : -1;
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("request_ready", 32'(bus.request_ready), 32'(exp_ready));
    if (sb.size() > 0) begin
      check("response_valid", 32'(bus.response_valid), 32'd1);
      check("response_data", 32'(bus.response_data), 32'(sb[0].data));
      check("response_index", 32'(bus.response_index), sb[0].idx);
    end else begin
      check("response_valid", 32'(bus.response_valid), 32'd0);
    end
    fire = (sb.size() > 0) && bus.response_ready;
    if (g >= 0) begin
      nr.idx  = g;
      nr.data = rotl(bus.request_data[g*DW +: DW], int'(bus.request_rotation[g*RW +: RW]));
    end
    @(posedge clock);
    #1;
    if (fire) void'(sb.pop_front());
    if (g >= 0) begin
      sb.push_back(nr);
      ptr_m = FIXED ? 0 : (g + 1) % NR;
    end
    last_grant = g;
  endtask

  initial begin
    logic [DW-1:0] held;
    resetn               = 1'b0;
    bus.request_valid    = '1;
    bus.request_data     = '0;
    bus.request_rotation = '0;
    bus.response_ready   = 1'b0;
    #2;
    check("reset_valid", 32'(bus.response_valid), 32'd0);
    check("reset_data", 32'(bus.response_data), 32'd0);
    check("reset_index", 32'(bus.response_index), 32'd0);
    check("reset_ready", 32'(bus.request_ready), 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;

    // Fairness: all clients valid, downstream always ready.
    bus.request_valid  = 4'b1111;
    bus.response_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, DW'(8'h11 * (i + 1)), RW'(i));
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("fair_grant", 32'(last_grant), FIXED ? 32'd0 : 32'(i % NR));
    end

    // Walking one from client 1.
    bus.request_valid = 4'b0010;
    for (int r = 0; r < 8; r++) begin
      set_req(1, 8'h01, RW'(r));
      cycle();
      check("walk_data", 32'(bus.response_data), 32'(8'h01 << r));
      check("walk_index", 32'(bus.response_index), 32'd1);
    end

    // Wrap-around values.
    bus.request_valid = 4'b0001;
    set_req(0, 8'hC3, 3'd3);
    cycle();
    check("wrap_c3", 32'(bus.response_data), 32'h1E);
    set_req(0, 8'hFE, 3'd7);
    cycle();
    check("wrap_fe", 32'(bus.response_data), 32'h7F);
    bus.request_valid = '0;
    cycle();

    // Backpressure: fill, stall five cycles, then drain and refill together.
    bus.request_valid = 4'b0001;
    set_req(0, 8'hA5, 3'd1);
    cycle();
    bus.request_valid  = 4'b1111;
    bus.response_ready = 1'b0;
    held = 8'h4B;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_ready", 32'(bus.request_ready), 32'd0);
      check("bp_data", 32'(bus.response_data), 32'(held));
    end
    bus.response_ready = 1'b1;
    cycle();
    check("bp_refill_grant", 32'(last_grant), FIXED ? 32'd0 : 32'd1);
    check("bp_refill_valid", 32'(bus.response_valid), 32'd1);

    // Asynchronous reset while full with clients 2 and 3 pending.
    bus.request_valid  = 4'b0001;
    cycle();
    bus.request_valid  = 4'b1100;
    bus.response_ready = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check("rst_mid_valid", 32'(bus.response_valid), 32'd0);
    check("rst_mid_data", 32'(bus.response_data), 32'd0);
    check("rst_mid_ready", 32'(bus.request_ready), 32'd0);
    sb.delete();
    ptr_m  = 0;
    resetn = 1'b1;
    cycle();
    check("rst_first_grant", 32'(last_grant), 32'd2);

    // Random traffic.
    for (int n = 0; n < 1000; n++) begin
      bus.request_valid    = NR'($urandom);
      bus.request_data     = (NR*DW)'($urandom);
      bus.request_rotation = (NR*RW)'($urandom);
      bus.response_ready   = ($urandom_range(0, 3) != 0);
      cycle();
    end

    bus.request_valid  = '0;
    bus.response_ready = 1'b1;
    repeat (3) cycle();
    check("drain_empty", 32'(bus.response_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
